// File: rtl/alu_op_issuer.sv
// alu_op_issuer: execute-stage ALU front end (decode, operand issue, result capture); ALU_ISSUE_ILLEGAL_TRAP_EN enables the illegal-instruction trap
module alu_op_issuer #(
    parameter int DATA_W = 32,
    parameter int OPRN_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OPRN_W-1:0] alu_oprn,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic [5:0]        opcode, funct, dec_code;
    logic [DATA_W-1:0] dec_op1, dec_op2, se_imm, ze_imm, ze_shamt;
    logic              dec_ill, trap, accept;
    logic              unused_instr;
    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign se_imm       = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign ze_imm       = DATA_W'(instr[15:0]);
    assign ze_shamt     = DATA_W'(instr[10:6]);
    assign unused_instr = ^instr[25:16];
    assign accept       = in_valid && in_ready;
    assign trap         = TRAP_EN && dec_ill;
    // decode opcode/funct into ALU operation and operand selection
    always_comb begin
        dec_code = 6'h00;
        dec_op1  = rs_data;
        dec_op2  = rt_data;
        dec_ill  = 1'b0;
        case (opcode)
            6'h00:
                case (funct)
                    6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a: dec_code = funct;
                    6'h01, 6'h02: begin
                        dec_code = funct;
                        dec_op1  = rt_data;
                        dec_op2  = ze_shamt;
                    end
                    default: dec_ill = 1'b1;
                endcase
            6'h08, 6'h23, 6'h2b: begin
                dec_code = 6'h20;
                dec_op2  = se_imm;
            end
            6'h1d: begin
                dec_code = 6'h2c;
                dec_op2  = se_imm;
            end
            6'h0a: begin
                dec_code = 6'h2a;
                dec_op2  = se_imm;
            end
            6'h0c: begin
                dec_code = 6'h24;
                dec_op2  = ze_imm;
            end
            6'h0d: begin
                dec_code = 6'h25;
                dec_op2  = ze_imm;
            end
            6'h04, 6'h05: dec_code = 6'h22;
            6'h0f: begin
                dec_code = 6'h01;
                dec_op1  = ze_imm;
                dec_op2  = DATA_W'(16);
            end
            default: dec_ill = 1'b1;
        endcase
    end
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    // next state: trapped instructions skip EXEC
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (trap ? DONE : EXEC) : IDLE;
            EXEC:    state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // handshake outputs; ready held low while reset is asserted
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end
    // operand issue on acceptance, result capture in EXEC (or cleared on trap)
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_oprn  <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (accept && !trap) begin
                alu_op1  <= dec_op1;
                alu_op2  <= dec_op2;
                alu_oprn <= OPRN_W'(dec_code);
            end
            if (state == EXEC) begin
                result    <= alu_out;
                zero_flag <= alu_zero;
            end else if (accept && trap) begin
                result    <= '0;
                zero_flag <= 1'b0;
            end
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    // illegal flag: set on trapped acceptance, cleared by the result handshake
    always_ff @(posedge clk or posedge rst)
        if (rst)                         illegal <= 1'b0;
        else if (accept && trap)         illegal <= 1'b1;
        else if (out_valid && out_ready) illegal <= 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed self-checking bench for alu_op_issuer with a behavioural ALU
module tb_alu_op_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] alu_op1, alu_op2, alu_out, result;
    logic [5:0]  alu_oprn;
    logic        alu_zero, out_valid, zero_flag;
    logic        out_ready = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    int n_chk = 0;
    int n_fail = 0;

    alu_op_issuer #(.DATA_W(32), .OPRN_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    // behavioural ALU; unknown codes drive a recognisable marker
    always_comb begin
        case (alu_oprn)
            6'h20:   alu_out = alu_op1 + alu_op2;
            6'h22:   alu_out = alu_op1 - alu_op2;
            6'h2c:   alu_out = alu_op1 * alu_op2;
            6'h24:   alu_out = alu_op1 & alu_op2;
            6'h25:   alu_out = alu_op1 | alu_op2;
            6'h27:   alu_out = ~(alu_op1 | alu_op2);
            6'h2a:   alu_out = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            6'h01:   alu_out = alu_op1 << alu_op2[4:0];
            6'h02:   alu_out = alu_op1 >> alu_op2[4:0];
            default: alu_out = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one instruction with OUT_READY high and check the full 3-cycle sequence
    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [5:0] e_oprn, input logic [31:0] e_op1, input logic [31:0] e_op2,
                          input logic [31:0] e_res, input logic e_zero);
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, ".in_ready_pre"}, in_ready, 1);
        in_valid = 1'b1; instr = ins; rs_data = rs; rt_data = rt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".oprn"}, alu_oprn, e_oprn);
        chk({tag, ".op1"}, alu_op1, e_op1);
        chk({tag, ".op2"}, alu_op2, e_op2);
        chk({tag, ".exec_ready"}, in_ready, 0);
        chk({tag, ".exec_valid"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".result"}, result, e_res);
        chk({tag, ".zero"}, zero_flag, e_zero);
        @(posedge clk); #1;
        chk({tag, ".done_valid"}, out_valid, 0);
        chk({tag, ".in_ready_post"}, in_ready, 1);
    endtask

    initial begin
        #12;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.oprn", alu_oprn, 0);
        chk("rst.op1", alu_op1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.release_ready", in_ready, 1);

        run_op("add",  32'h0022_1820, 32'd5, 32'd7, 6'h20, 32'd5, 32'd7, 32'd12, 1'b0);
        run_op("beq",  32'h1022_0003, 32'h1234, 32'h1234, 6'h22, 32'h1234, 32'h1234, 32'd0, 1'b1);
        run_op("addi", 32'h2022_FFFF, 32'd1, 32'd9, 6'h20, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_op("andi", 32'h3022_FFFF, 32'h1234_5678, 32'd0, 6'h24, 32'h1234_5678, 32'h0000_FFFF, 32'h5678, 1'b0);
        run_op("lui",  32'h3C02_ABCD, 32'h55, 32'd0, 6'h01, 32'h0000_ABCD, 32'd16, 32'hABCD_0000, 1'b0);
        run_op("sll",  32'h0002_1901, 32'h77, 32'd1, 6'h01, 32'd1, 32'd4, 32'h10, 1'b0);
        run_op("slti", 32'h2822_FFFF, 32'hFFFF_FFFE, 32'd0, 6'h2a, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("ori",  32'h3422_1000, 32'h0000_000F, 32'd0, 6'h25, 32'h0000_000F, 32'h0000_1000, 32'h0000_100F, 1'b0);
        run_op("nor",  32'h0022_1827, 32'd0, 32'd0, 6'h27, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("sw",   32'hAC22_FFFC, 32'h100, 32'd3, 6'h20, 32'h100, 32'hFFFF_FFFC, 32'h0FC, 1'b0);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        @(negedge clk);
        in_valid = 1'b1; instr = 32'hFC22_1820; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("trap.out_valid", out_valid, 1);
        chk("trap.illegal", illegal, 1);
        chk("trap.result", result, 0);
        chk("trap.zero", zero_flag, 0);
        chk("trap.oprn_held", alu_oprn, 6'h20);
        @(posedge clk); #1;
        chk("trap.done_valid", out_valid, 0);
        chk("trap.illegal_clr", illegal, 0);
`else
        run_op("illegal", 32'hFC22_1820, 32'd3, 32'd4, 6'h00, 32'd3, 32'd4, 32'hDEAD_BEEF, 1'b0);
`endif

        // back-pressure: result held, new request ignored for 5 cycles
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h0022_1820; rs_data = 32'd10; rt_data = 32'd20;
        @(posedge clk); #1;
        instr = 32'h0022_1822; rs_data = 32'd99; rt_data = 32'd1;
        @(posedge clk); #1;
        chk("bp.out_valid", out_valid, 1);
        chk("bp.result", result, 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_result", result, 32'd30);
            chk("bp.hold_ready", in_ready, 0);
            chk("bp.hold_op1", alu_op1, 32'd10);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_valid", out_valid, 0);
        chk("bp.release_ready", in_ready, 1);

        // reset while DONE
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h0022_1820; rs_data = 32'd1; rt_data = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid.done_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid.out_valid", out_valid, 0);
        chk("mid.result", result, 0);
        chk("mid.oprn", alu_oprn, 0);
        chk("mid.in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid.ready_after", in_ready, 1);
        chk("mid.valid_after", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
